// File: rtl/jif_cpu_handler.sv
// Tiny 8-bit accumulator CPU: host loads a 16-byte unified memory through ui_in, then runs it.
// Result byte on uo_out, status flags on uio_out[7:4].
//
// mode  | meaning
// IDLE  | hold all state
// LOAD  | strobed byte writes at load_ptr; entering the mode rewinds load_ptr
// RUN   | execute one instruction per cycle until HLT
// CLEAR | reset pc/A/flags/halt/load_ptr, keep OUT and memory
module jif_cpu_handler #(
    parameter int MEM_DEPTH = 16,
    parameter bit RESET_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_RUN   = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_t;

    mode_t      mode;
    mode_t      prev_mode;
    logic [7:0] mem [MEM_DEPTH];
    logic [3:0] pc;
    logic [3:0] load_ptr;
    logic [7:0] acc;
    logic [7:0] out_reg;
    logic       z_flag;
    logic       c_flag;
    logic       halted;
    logic       strobe;
    logic       running;
    logic       unused_uio;

    logic [7:0] instr;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [7:0] mem_operand;

    logic [7:0] nxt_acc;
    logic [7:0] nxt_out;
    logic [3:0] nxt_pc;
    logic       nxt_c;
    logic       nxt_z;
    logic       nxt_halted;
    logic       upd_z;
    logic       sta_we;
    logic [8:0] sum9;

    assign mode       = mode_t'(uio_in[1:0]);
    assign strobe     = uio_in[2];
    assign unused_uio = &{1'b0, uio_in[7:3]};

    assign instr       = mem[pc];
    assign opcode      = instr[7:4];
    assign operand     = instr[3:0];
    assign mem_operand = mem[operand];

    always_comb begin
        nxt_acc    = acc;
        nxt_out    = out_reg;
        nxt_pc     = pc + 4'd1;
        nxt_c      = c_flag;
        nxt_halted = halted;
        upd_z      = 1'b0;
        sta_we     = 1'b0;
        sum9       = 9'd0;
        case (opcode)
            4'h1: begin nxt_acc = {4'b0, operand}; upd_z = 1'b1; end
            4'h2: begin nxt_acc = mem_operand; upd_z = 1'b1; end
            4'h3: sta_we = 1'b1;
            4'h4: begin
                sum9    = {1'b0, acc} + {1'b0, mem_operand};
                nxt_acc = sum9[7:0];
                nxt_c   = sum9[8];
                upd_z   = 1'b1;
            end
            4'h5: begin
                nxt_acc = acc - mem_operand;
                nxt_c   = (acc < mem_operand);
                upd_z   = 1'b1;
            end
            4'h6: begin nxt_acc = acc & mem_operand; nxt_c = 1'b0; upd_z = 1'b1; end
            4'h7: begin nxt_acc = acc | mem_operand; nxt_c = 1'b0; upd_z = 1'b1; end
            4'h8: begin nxt_acc = acc ^ mem_operand; nxt_c = 1'b0; upd_z = 1'b1; end
            4'h9: nxt_pc = operand;
            4'hA: if (z_flag) nxt_pc = operand;
            4'hB: if (c_flag) nxt_pc = operand;
            4'hC: nxt_out = acc;
            4'hD: begin
                sum9    = {1'b0, acc} + 9'd1;
                nxt_acc = sum9[7:0];
                nxt_c   = sum9[8];
                upd_z   = 1'b1;
            end
            4'hE: begin nxt_acc = {acc[6:0], 1'b0}; nxt_c = acc[7]; upd_z = 1'b1; end
            4'hF: begin nxt_halted = 1'b1; nxt_pc = pc; end
            default: ;
        endcase
        nxt_z = upd_z ? (nxt_acc == 8'h00) : z_flag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= 4'd0;
            acc       <= 8'h00;
            out_reg   <= 8'h00;
            z_flag    <= 1'b0;
            c_flag    <= 1'b0;
            halted    <= 1'b0;
            load_ptr  <= 4'd0;
            prev_mode <= MODE_IDLE;
            if (RESET_MEM) begin
                for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
            end
        end else if (ena) begin
            prev_mode <= mode;
            case (mode)
                MODE_LOAD: begin
                    // First LOAD cycle only rewinds the pointer, so a held strobe cannot land mid-memory.
                    if (prev_mode != MODE_LOAD) begin
                        load_ptr <= 4'd0;
                    end else if (strobe) begin
                        mem[load_ptr] <= ui_in;
                        load_ptr      <= load_ptr + 4'd1;
                    end
                end
                MODE_RUN: begin
                    if (!halted) begin
                        pc      <= nxt_pc;
                        acc     <= nxt_acc;
                        out_reg <= nxt_out;
                        z_flag  <= nxt_z;
                        c_flag  <= nxt_c;
                        halted  <= nxt_halted;
                        if (sta_we) mem[operand] <= acc;
                    end
                end
                MODE_CLEAR: begin
                    pc       <= 4'd0;
                    acc      <= 8'h00;
                    z_flag   <= 1'b0;
                    c_flag   <= 1'b0;
                    halted   <= 1'b0;
                    load_ptr <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign running = (mode == MODE_RUN) && !halted;
    assign uo_out  = out_reg;
    assign uio_out = {c_flag, z_flag, running, halted, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_jif_cpu_handler.sv
// Directed bench for jif_cpu_handler: an ISA-level reference model is compared on every cycle,
// plus literal end-of-program expectations for each scenario.
module tb_jif_cpu_handler;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, CLR = 2'b11;

    // reference machine state
    logic [7:0] m_mem [16];
    int         m_pc, m_lp, m_a, m_out;
    bit         m_z, m_c, m_halt;
    logic [1:0] m_prev;

    logic [7:0] prog_q [$];
    logic [7:0] seen_q [$];

    jif_cpu_handler #(.MEM_DEPTH(16), .RESET_MEM(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_exec();
        int ins, op, n, m, r;
        ins = m_mem[m_pc];
        op  = ins / 16;
        n   = ins % 16;
        m   = m_mem[n];
        r   = m_a;
        m_pc = (m_pc + 1) % 16;
        case (op)
            1:  r = n;
            2:  r = m;
            3:  m_mem[n] = 8'(m_a);
            4:  begin r = m_a + m; m_c = (r > 255); r = r % 256; end
            5:  begin m_c = (m_a < m); r = (m_a - m + 256) % 256; end
            6:  begin r = m_a & m; m_c = 0; end
            7:  begin r = m_a | m; m_c = 0; end
            8:  begin r = m_a ^ m; m_c = 0; end
            9:  m_pc = n;
            10: if (m_z) m_pc = n;
            11: if (m_c) m_pc = n;
            12: m_out = m_a;
            13: begin r = m_a + 1; m_c = (r > 255); r = r % 256; end
            14: begin m_c = (m_a >= 128); r = (m_a * 2) % 256; end
            15: begin m_halt = 1; m_pc = (m_pc + 15) % 16; end
            default: ;
        endcase
        if (op inside {1, 2, 4, 5, 6, 7, 8, 13, 14}) begin
            m_a = r;
            m_z = (r == 0);
        end
    endtask

    task automatic model_tick();
        logic [1:0] md;
        md = uio_in[1:0];
        if (rst) begin
            m_pc = 0; m_a = 0; m_out = 0; m_z = 0; m_c = 0; m_halt = 0; m_lp = 0;
            m_prev = IDLE;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end else if (ena) begin
            if (md == LOAD) begin
                if (m_prev != LOAD) m_lp = 0;
                else if (uio_in[2]) begin
                    m_mem[m_lp] = ui_in;
                    m_lp = (m_lp + 1) % 16;
                end
            end else if (md == RUN) begin
                if (!m_halt) model_exec();
            end else if (md == CLR) begin
                m_pc = 0; m_a = 0; m_z = 0; m_c = 0; m_halt = 0; m_lp = 0;
            end
            m_prev = md;
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_uio;
        exp_uio = {m_c, m_z, (uio_in[1:0] == RUN) && !m_halt, m_halt, 4'b0000};
        check8("uo_out", uo_out, 8'(m_out));
        check8("uio_out", uio_out, exp_uio);
        check8("uio_oe", uio_oe, 8'hF0);
    endtask

    task automatic step(input bit r, input bit e, input logic [1:0] md, input bit st,
                        input logic [7:0] d);
        rst    = r;
        ena    = e;
        uio_in = {5'b0, st, md};
        ui_in  = d;
        @(posedge clk);
        model_tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic load_prog();
        step(0, 1, IDLE, 0, 8'h00);
        step(0, 1, LOAD, 1, 8'h99);
        foreach (prog_q[i]) step(0, 1, LOAD, 1, prog_q[i]);
        step(0, 1, IDLE, 0, 8'h00);
    endtask

    task automatic run(input int n);
        repeat (n) step(0, 1, RUN, 0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        @(negedge clk);

        // reset and idle
        step(1, 1, IDLE, 0, 8'h00);
        step(1, 1, IDLE, 0, 8'h00);
        check8("rst_uo", uo_out, 8'h00);
        check8("rst_uio", uio_out, 8'h00);
        check8("rst_oe", uio_oe, 8'hF0);
        step(0, 1, IDLE, 0, 8'h00);
        step(0, 1, IDLE, 0, 8'h00);
        check8("idle_uio", uio_out, 8'h00);

        // load + add: LDI 5, ADD mem[10]=7, OUT, HLT
        prog_q = '{8'h15, 8'h4A, 8'hC0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
        load_prog();
        step(0, 1, CLR, 0, 8'h00);
        run(4);
        check8("add_uo", uo_out, 8'h0C);
        check8("add_uio", uio_out, 8'h10);

        // carry and zero: 1 + FF
        prog_q = '{8'h11, 8'h48, 8'hC0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        load_prog();
        step(0, 1, CLR, 0, 8'h00);
        run(4);
        check8("cz_uo", uo_out, 8'h00);
        check8("cz_flags", {6'b0, uio_out[7:6]}, 8'h03);
        check8("cz_uio", uio_out, 8'hD0);

        // SUB/JC/AND/OR/XOR/SHL/STA/LDA
        prog_q = '{8'h1A, 8'h5F, 8'hB4, 8'hF0, 8'h6E, 8'h7D, 8'h8D, 8'hE0,
                   8'h3C, 8'h2C, 8'hC0, 8'hF0, 8'h00, 8'h30, 8'h0F, 8'h0C};
        load_prog();
        step(0, 1, CLR, 0, 8'h00);
        run(12);
        check8("alu_uo", uo_out, 8'h1C);
        check8("alu_uio", uio_out, 8'h10);

        // INC loop from FD with JZ exit, plus ena freeze and IDLE pause
        prog_q = '{8'h2F, 8'hD0, 8'hC0, 8'hA5, 8'h91, 8'hF0, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD};
        load_prog();
        step(0, 1, CLR, 0, 8'h00);
        run(3);
        check8("loop_first", uo_out, 8'hFE);
        check8("loop_running", {7'b0, uio_out[5]}, 8'h01);
        repeat (5) begin
            step(0, 0, RUN, 0, 8'h00);
            check8("ena_frozen", uo_out, 8'hFE);
        end
        step(0, 1, IDLE, 0, 8'h00);
        step(0, 1, IDLE, 0, 8'h00);
        seen_q = '{uo_out};
        for (int i = 0; i < 20; i++) begin
            step(0, 1, RUN, 0, 8'h00);
            if (uo_out != seen_q[$]) seen_q.push_back(uo_out);
        end
        check8("loop_nvals", 8'(seen_q.size()), 8'd3);
        if (seen_q.size() == 3) begin
            check8("loop_v1", seen_q[1], 8'hFF);
            check8("loop_v2", seen_q[2], 8'h00);
        end
        check8("loop_final_uio", uio_out, 8'hD0);
        step(0, 1, CLR, 0, 8'h00);
        check8("clear_unhalt", uio_out, 8'h00);
        check8("clear_keeps_out", uo_out, 8'h00);

        // 17 strobes wrap: byte 17 lands at addr 0
        prog_q.delete();
        prog_q.push_back(8'hEE);
        prog_q.push_back(8'hC0);
        prog_q.push_back(8'hF0);
        for (int i = 3; i < 15; i++) prog_q.push_back(8'h00);
        prog_q.push_back(8'h5A);
        prog_q.push_back(8'h2F);
        load_prog();
        step(0, 1, CLR, 0, 8'h00);
        run(4);
        check8("wrap_uo", uo_out, 8'h5A);

        // re-entering LOAD restarts at addr 0
        prog_q = '{8'h1F};
        load_prog();
        step(0, 1, CLR, 0, 8'h00);
        run(4);
        check8("reentry_uo", uo_out, 8'h0F);
        check8("reentry_uio", uio_out, 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
